dac_sample_pacer: RTL and testbench
===================================

// Module: dac_sample_pacer
// PURPOSE
//  Upstream stage of the mcp4921 SPI DAC driver. Buffers 12-bit samples from a producer in a FIFO.
//  Releases them at a fixed sample rate as an o_data word plus an o_trig pulse.
//  o_data/o_trig connect directly to the driver's i_data/i_trig, so DAC updates are jitter-free.
//  Flags FIFO underrun so software can detect sample starvation.
// PARAMETERS
//  DATA_W    12    sample width; matches the DAC driver's i_data width
//  FIFO_AW   4     FIFO address bits; depth = 2**FIFO_AW = 16
//  RATE_DIV  1000  CLK cycles per sample period; must exceed one full SPI frame of the DAC driver
//  TRIG_LEN  2     cycles o_trig is held high per sample; 1 <= TRIG_LEN < RATE_DIV
// PORTS
//  CLK             in   1          system clock, all logic on rising edge
//  RSTn            in   1          asynchronous active-low reset
//  i_data          in   DATA_W     producer sample
//  i_valid         in   1          producer sample valid
//  o_ready         out  1          FIFO can accept; a write occurs when i_valid && o_ready
//  i_enable        in   1          run sample-rate timer; 0 = paused
//  i_clr_underrun  in   1          one-cycle clear of o_underrun
//  o_data          out  DATA_W     sample presented to the DAC driver
//  o_trig          out  1          DAC driver start pulse
//  o_level         out  FIFO_AW+1  FIFO occupancy, 0..2**FIFO_AW
//  o_empty         out  1          o_level == 0
//  o_full          out  1          o_level == 2**FIFO_AW
//  o_underrun      out  1          sticky: a sample tick found the FIFO empty
// BEHAVIOUR
//  Reset values: o_data=0, o_trig=0, o_level=0, o_empty=1, o_full=0, o_underrun=0, o_ready=1.
//  Reset state: rate counter=0, FSM=S_WAIT, FIFO pointers=0.
//  Reset mid-operation aborts any trig pulse immediately and discards FIFO contents.
//  FIFO: o_ready = !o_full, combinational from registered level.
//    When full, writes are blocked even on a pop cycle.
//    Write and pop in the same cycle leave the level unchanged; pointers wrap modulo depth.
//  Rate counter: counts 0..RATE_DIV-1 while i_enable=1, then wraps.
//    tick = i_enable && count==RATE_DIV-1.
//    i_enable=0 forces count to 0 next cycle.
//    First tick comes RATE_DIV cycles after i_enable rises.
//  FSM
//    S_WAIT: on tick with FIFO non-empty (registered level, so a same-cycle write doesn't count):
//      pop the head into o_data (visible cycle T+1), load trig counter = TRIG_LEN, go S_TRIG.
//    S_WAIT: on tick with FIFO empty: o_data holds, no trig, set o_underrun next cycle.
//    S_TRIG: o_trig=1 for exactly TRIG_LEN cycles (T+1..T+TRIG_LEN), then return to S_WAIT.
//      Deasserting i_enable during S_TRIG does not shorten the pulse.
//  o_data is stable from T+1 until the next successful pop. The driver samples it while o_trig=1.
//  o_underrun: set has priority over i_clr_underrun in the same cycle; cleared only by clear or reset.
//  Latency: a sample written into an empty FIFO appears on o_data 1 cycle after the next tick.
// TESTING
//  1 Reset: RSTn=0 mid-S_TRIG with FIFO level 5 -> o_trig=0, o_level=0, o_ready=1 immediately, asynchronously.
//  2 Pacing (RATE_DIV=8, TRIG_LEN=2): write 0x017,0xABC,0xFFF, then enable.
//    -> o_trig high at cycles 9-10, 17-18, 25-26; o_data =0x017, 0xABC, 0xFFF in turn.
//  3 Full: write 17 samples with RATE_DIV large -> o_full=1, o_ready=0 after the 16th; 17th not accepted; o_level=16.
//  4 Underrun: empty FIFO, enable, wait one period -> no o_trig, o_data unchanged, o_underrun=1.
//    Assert i_clr_underrun on a tick that also underruns -> o_underrun stays 1.
//  5 Simultaneous: level 1, write on the tick cycle -> pop occurs, o_level stays 1, written value emitted next period.
//  6 Pause: drop i_enable at count 5 -> counter to 0, no tick; re-enable -> next tick RATE_DIV cycles later.

Source files
------------

// File: rtl/dac_sample_pacer.sv
// Sample pacer for the MCP4921 DAC driver: buffers producer samples in a FIFO and
// releases one per RATE_DIV clocks as an o_data word plus a TRIG_LEN-cycle o_trig pulse.
module dac_sample_pacer #(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned FIFO_AW  = 4,
    parameter int unsigned RATE_DIV = 1000,
    parameter int unsigned TRIG_LEN = 2
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic [DATA_W-1:0]    i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_enable,
    input  logic                 i_clr_underrun,
    output logic [DATA_W-1:0]    o_data,
    output logic                 o_trig,
    output logic [FIFO_AW:0]     o_level,
    output logic                 o_empty,
    output logic                 o_full,
    output logic                 o_underrun
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned CNT_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam int unsigned TCW   = $clog2(TRIG_LEN + 1);

    typedef enum logic [0:0] {S_WAIT, S_TRIG} state_e;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               underrun_q, underrun_d;

    state_e             state_q;
    logic [TCW-1:0]     trig_cnt_q;
    logic [DATA_W-1:0]  data_q;
    logic               trig_q;

    logic full, empty, push, pop, tick, starve;

    assign full    = (level_q == (FIFO_AW + 1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign push    = i_valid && !full;
    assign tick    = i_enable && (cnt_q == CNT_W'(RATE_DIV - 1));
    // Level is the registered value, so a write landing on the tick cycle cannot be popped.
    assign pop     = (state_q == S_WAIT) && tick && !empty;
    assign starve  = (state_q == S_WAIT) && tick && empty;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (!i_enable || tick) cnt_d = '0;
        else                   cnt_d = cnt_q + 1'b1;

        if (starve)              underrun_d = 1'b1;
        else if (i_clr_underrun) underrun_d = 1'b0;
        else                     underrun_d = underrun_q;
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= i_data;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= S_WAIT;
            trig_cnt_q <= '0;
            data_q     <= '0;
            trig_q     <= 1'b0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (pop) begin
                        data_q     <= mem_q[rd_ptr_q];
                        trig_cnt_q <= TCW'(TRIG_LEN);
                        trig_q     <= 1'b1;
                        state_q    <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    // Runs to completion regardless of i_enable.
                    if (trig_cnt_q <= TCW'(1)) begin
                        trig_cnt_q <= '0;
                        trig_q     <= 1'b0;
                        state_q    <= S_WAIT;
                    end else begin
                        trig_cnt_q <= trig_cnt_q - 1'b1;
                    end
                end
                default: begin
                    trig_q  <= 1'b0;
                    state_q <= S_WAIT;
                end
            endcase
        end
    end

    assign o_ready    = !full;
    assign o_data     = data_q;
    assign o_trig     = trig_q;
    assign o_level    = level_q;
    assign o_empty    = empty;
    assign o_full     = full;
    assign o_underrun = underrun_q;

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Directed bench for dac_sample_pacer with RATE_DIV=8, TRIG_LEN=2, depth 16.
module tb_dac_sample_pacer;

    logic        CLK;
    logic        RSTn;
    logic [11:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic        i_enable;
    logic        i_clr_underrun;
    logic [11:0] o_data;
    logic        o_trig;
    logic [4:0]  o_level;
    logic        o_empty;
    logic        o_full;
    logic        o_underrun;

    int checks = 0;
    int errors = 0;

    dac_sample_pacer #(
        .DATA_W  (12),
        .FIFO_AW (4),
        .RATE_DIV(8),
        .TRIG_LEN(2)
    ) dut (
        .CLK           (CLK),
        .RSTn          (RSTn),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_enable      (i_enable),
        .i_clr_underrun(i_clr_underrun),
        .o_data        (o_data),
        .o_trig        (o_trig),
        .o_level       (o_level),
        .o_empty       (o_empty),
        .o_full        (o_full),
        .o_underrun    (o_underrun)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_one(input logic [11:0] d);
        i_valid = 1'b1;
        i_data  = d;
        step();
        i_valid = 1'b0;
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        i_valid = 1'b0;
        i_enable = 1'b0;
        i_clr_underrun = 1'b0;
        i_data = '0;
        step();
        step();
        RSTn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        i_valid = 1'b0;
        i_enable = 1'b0;
        i_clr_underrun = 1'b0;
        i_data = '0;
        #1;
        checks++;
        if ({o_data, o_trig, o_level, o_empty, o_full, o_underrun, o_ready}
            !== {12'h000, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: data=%h trig=%b level=%0d empty=%b full=%b unr=%b rdy=%b",
                     o_data, o_trig, o_level, o_empty, o_full, o_underrun, o_ready);
        end
        step();
        RSTn = 1'b1;
        step();
        for (int i = 0; i < 6; i++) write_one(12'h100 + 12'(i));
        i_enable = 1'b1;
        for (int n = 0; n < 8; n++) step();
        checks++;
        if (o_trig !== 1'b1 || o_level !== 5'd5) begin
            errors++;
            $display("FAIL reset_setup: trig=%b level=%0d, required trig=1 level=5", o_trig, o_level);
        end
        #2;
        RSTn = 1'b0;
        i_enable = 1'b0;
        #1;
        checks++;
        if (o_trig !== 1'b0 || o_level !== 5'd0 || o_ready !== 1'b1 || o_data !== 12'h000) begin
            errors++;
            $display("FAIL reset_async: trig=%b level=%0d ready=%b data=%h, required 0 0 1 000",
                     o_trig, o_level, o_ready, o_data);
        end
        step();
        RSTn = 1'b1;
        step();
    endtask

    task automatic test_pacing();
        logic [11:0] exp_d;
        logic        exp_t;
        write_one(12'h017);
        write_one(12'hABC);
        write_one(12'hFFF);
        i_enable = 1'b1;
        for (int n = 1; n <= 26; n++) begin
            int cyc;
            step();
            cyc = n + 1;
            exp_t = (cyc == 9 || cyc == 10 || cyc == 17 || cyc == 18 || cyc == 25 || cyc == 26);
            checks++;
            if (o_trig !== exp_t) begin
                errors++;
                $display("FAIL pacing_trig cycle %0d: got %b required %b", cyc, o_trig, exp_t);
            end
            if (cyc == 9 || cyc == 17 || cyc == 25) begin
                exp_d = (cyc == 9) ? 12'h017 : (cyc == 17) ? 12'hABC : 12'hFFF;
                checks++;
                if (o_data !== exp_d) begin
                    errors++;
                    $display("FAIL pacing_data cycle %0d: got %h required %h", cyc, o_data, exp_d);
                end
            end
        end
        i_enable = 1'b0;
        step();
        checks++;
        if (o_level !== 5'd0 || o_empty !== 1'b1 || o_underrun !== 1'b0) begin
            errors++;
            $display("FAIL pacing_end: level=%0d empty=%b unr=%b, required 0 1 0",
                     o_level, o_empty, o_underrun);
        end
    endtask

    task automatic test_underrun();
        i_enable = 1'b1;
        for (int n = 0; n < 7; n++) step();
        checks++;
        if (o_underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_early: got %b required 0", o_underrun);
        end
        step();
        checks++;
        if (o_trig !== 1'b0 || o_data !== 12'hFFF || o_underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_set: trig=%b data=%h unr=%b, required 0 fff 1",
                     o_trig, o_data, o_underrun);
        end
        for (int n = 0; n < 7; n++) step();
        i_clr_underrun = 1'b1;
        step();
        i_clr_underrun = 1'b0;
        checks++;
        if (o_underrun !== 1'b1 || o_trig !== 1'b0) begin
            errors++;
            $display("FAIL underrun_priority: unr=%b trig=%b, required 1 0", o_underrun, o_trig);
        end
        i_clr_underrun = 1'b1;
        step();
        i_clr_underrun = 1'b0;
        checks++;
        if (o_underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_clear: got %b required 0", o_underrun);
        end
        i_enable = 1'b0;
        step();
    endtask

    task automatic test_simultaneous();
        write_one(12'h123);
        i_enable = 1'b1;
        for (int n = 0; n < 7; n++) step();
        i_valid = 1'b1;
        i_data  = 12'h456;
        step();
        i_valid = 1'b0;
        checks++;
        if (o_level !== 5'd1 || o_data !== 12'h123 || o_trig !== 1'b1) begin
            errors++;
            $display("FAIL simul_pop: level=%0d data=%h trig=%b, required 1 123 1",
                     o_level, o_data, o_trig);
        end
        for (int n = 0; n < 8; n++) step();
        checks++;
        if (o_level !== 5'd0 || o_data !== 12'h456 || o_trig !== 1'b1) begin
            errors++;
            $display("FAIL simul_next: level=%0d data=%h trig=%b, required 0 456 1",
                     o_level, o_data, o_trig);
        end
        i_enable = 1'b0;
        step();
        checks++;
        if (o_trig !== 1'b1) begin
            errors++;
            $display("FAIL trig_hold: got %b required 1", o_trig);
        end
        step();
        checks++;
        if (o_trig !== 1'b0) begin
            errors++;
            $display("FAIL trig_end: got %b required 0", o_trig);
        end
    endtask

    task automatic test_pause();
        write_one(12'h0AA);
        i_enable = 1'b1;
        for (int n = 0; n < 5; n++) step();
        i_enable = 1'b0;
        for (int n = 0; n < 6; n++) begin
            step();
            checks++;
            if (o_trig !== 1'b0) begin
                errors++;
                $display("FAIL pause_notick step %0d: trig=%b required 0", n, o_trig);
            end
        end
        checks++;
        if (o_level !== 5'd1) begin
            errors++;
            $display("FAIL pause_level: got %0d required 1", o_level);
        end
        i_enable = 1'b1;
        for (int n = 0; n < 7; n++) begin
            step();
            checks++;
            if (o_trig !== 1'b0) begin
                errors++;
                $display("FAIL pause_restart step %0d: trig=%b required 0", n, o_trig);
            end
        end
        step();
        checks++;
        if (o_trig !== 1'b1 || o_data !== 12'h0AA || o_level !== 5'd0) begin
            errors++;
            $display("FAIL pause_tick: trig=%b data=%h level=%0d, required 1 0aa 0",
                     o_trig, o_data, o_level);
        end
        i_enable = 1'b0;
        step();
        step();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) write_one(12'(i));
        checks++;
        if (o_level !== 5'd16 || o_full !== 1'b1 || o_ready !== 1'b0 || o_empty !== 1'b0) begin
            errors++;
            $display("FAIL full_flags: level=%0d full=%b ready=%b empty=%b, required 16 1 0 0",
                     o_level, o_full, o_ready, o_empty);
        end
        write_one(12'd16);
        checks++;
        if (o_level !== 5'd16) begin
            errors++;
            $display("FAIL full_block: level=%0d required 16", o_level);
        end
        i_enable = 1'b1;
        for (int n = 0; n < 128; n++) step();
        checks++;
        if (o_level !== 5'd0 || o_data !== 12'd15 || o_underrun !== 1'b0) begin
            errors++;
            $display("FAIL full_drain: level=%0d data=%h unr=%b, required 0 00f 0",
                     o_level, o_data, o_underrun);
        end
        i_enable = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_pacing();
        test_underrun();
        test_simultaneous();
        test_pause();
        test_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
